// File: rtl/snoopy_bus_initiator.sv
// Bus-side master for the snooping cache: wins the bus, writes back a dirty victim,
// fetches the requested line word by word, then commits data, tag and state.
module snoopy_bus_initiator #(
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 4,
  parameter int TAG_WIDTH    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STATE_WIDTH  = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          cpu_request,
  input  logic [1:0]                                    cpu_command,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpu_address,
  input  logic                                          victim_write_back,
  input  logic [TAG_WIDTH-1:0]                          victim_tag,
  input  logic [STATE_WIDTH-1:0]                        new_state,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          bus_request,
  input  logic                                          bus_grant,
  output logic [1:0]                                    bus_command,
  output logic                                          bus_command_valid,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] mem_address,
  output logic                                          mem_read_enable,
  output logic                                          mem_write_enable,
  output logic [DATA_WIDTH-1:0]                         mem_data_out,
  input  logic [DATA_WIDTH-1:0]                         mem_data_in,
  input  logic                                          mem_function_complete,
  output logic [INDEX_WIDTH-1:0]                        cache_index,
  output logic [OFFSET_WIDTH-1:0]                       cache_offset,
  input  logic [DATA_WIDTH-1:0]                         cache_data_in,
  output logic [DATA_WIDTH-1:0]                         cache_data_out,
  output logic                                          cache_write_data,
  output logic [TAG_WIDTH-1:0]                          cache_tag_out,
  output logic                                          cache_write_tag,
  output logic [STATE_WIDTH-1:0]                        cache_state_out,
  output logic                                          cache_write_state
);

  localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  localparam logic [1:0] CMD_NONE           = 2'd0;
  localparam logic [1:0] CMD_BUS_INVALIDATE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ARBITRATE,
    WRITE_BACK,
    FETCH,
    INVALIDATE,
    COMMIT
  } state_t;

  state_t                  state, state_next;
  logic [OFFSET_WIDTH-1:0] word_count, word_count_next;
  logic                    releasing, releasing_next;
  logic                    last_word;
  logic                    accept_request;

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [1:0]              req_command;
  logic                    req_write_back;
  logic [TAG_WIDTH-1:0]    req_victim_tag;
  logic [STATE_WIDTH-1:0]  req_state;

  logic                    unused_offset_bits;
  assign unused_offset_bits = ^cpu_address[OFFSET_WIDTH-1:0];

  assign last_word      = &word_count;
  assign accept_request = (state == IDLE) && cpu_request && (cpu_command != CMD_NONE);

  // releasing marks the gap after an acknowledge: strobe stays low until complete falls
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      word_count     <= '0;
      releasing      <= 1'b0;
      req_tag        <= '0;
      req_index      <= '0;
      req_command    <= CMD_NONE;
      req_write_back <= 1'b0;
      req_victim_tag <= '0;
      req_state      <= '0;
    end else begin
      state      <= state_next;
      word_count <= word_count_next;
      releasing  <= releasing_next;
      if (accept_request) begin
        req_tag        <= cpu_address[ADDR_WIDTH-1 -: TAG_WIDTH];
        req_index      <= cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
        req_command    <= cpu_command;
        req_write_back <= victim_write_back;
        req_victim_tag <= victim_tag;
        req_state      <= new_state;
      end
    end
  end

  always_comb begin
    state_next        = state;
    word_count_next   = word_count;
    releasing_next    = releasing;
    busy              = 1'b0;
    done              = 1'b0;
    bus_request       = 1'b0;
    bus_command       = CMD_NONE;
    bus_command_valid = 1'b0;
    mem_address       = '0;
    mem_read_enable   = 1'b0;
    mem_write_enable  = 1'b0;
    mem_data_out      = '0;
    cache_index       = '0;
    cache_offset      = '0;
    cache_data_out    = '0;
    cache_write_data  = 1'b0;
    cache_tag_out     = '0;
    cache_write_tag   = 1'b0;
    cache_state_out   = '0;
    cache_write_state = 1'b0;

    case (state)
      IDLE: begin
        word_count_next = '0;
        releasing_next  = 1'b0;
        if (accept_request) begin
          state_next = ARBITRATE;
        end
      end

      ARBITRATE: begin
        busy        = 1'b1;
        bus_request = 1'b1;
        cache_index = req_index;
        if (bus_grant) begin
          if (req_command == CMD_BUS_INVALIDATE) begin
            state_next = INVALIDATE;
          end else if (req_write_back) begin
            state_next = WRITE_BACK;
          end else begin
            state_next = FETCH;
          end
        end
      end

      WRITE_BACK: begin
        busy         = 1'b1;
        bus_request  = 1'b1;
        cache_index  = req_index;
        cache_offset = word_count;
        mem_address  = {req_victim_tag, req_index, word_count};
        mem_data_out = cache_data_in;
        if (!releasing) begin
          mem_write_enable = 1'b1;
          if (mem_function_complete) begin
            releasing_next = 1'b1;
          end
        end else if (!mem_function_complete) begin
          releasing_next  = 1'b0;
          word_count_next = word_count + 1'b1;
          if (last_word) begin
            state_next = FETCH;
          end
        end
      end

      // Each fetched word is written into the array in the cycle memory acknowledges it
      FETCH: begin
        busy              = 1'b1;
        bus_request       = 1'b1;
        bus_command       = req_command;
        bus_command_valid = 1'b1;
        cache_index       = req_index;
        cache_offset      = word_count;
        cache_data_out    = mem_data_in;
        mem_address       = {req_tag, req_index, word_count};
        if (!releasing) begin
          mem_read_enable = 1'b1;
          if (mem_function_complete) begin
            cache_write_data = 1'b1;
            releasing_next   = 1'b1;
          end
        end else if (!mem_function_complete) begin
          releasing_next  = 1'b0;
          word_count_next = word_count + 1'b1;
          if (last_word) begin
            state_next = COMMIT;
          end
        end
      end

      INVALIDATE: begin
        busy              = 1'b1;
        bus_request       = 1'b1;
        bus_command       = CMD_BUS_INVALIDATE;
        bus_command_valid = 1'b1;
        cache_index       = req_index;
        state_next        = COMMIT;
      end

      COMMIT: begin
        busy              = 1'b1;
        bus_request       = 1'b1;
        done              = 1'b1;
        cache_index       = req_index;
        cache_state_out   = req_state;
        cache_write_state = 1'b1;
        if (req_command != CMD_BUS_INVALIDATE) begin
          cache_tag_out   = req_tag;
          cache_write_tag = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/snoopy_bus_initiator.md
Name: snoopy_bus_initiator

Overview:
- Master-side counterpart of the snoopy controller: it issues BUS_READ, BUS_READ_EXCLUSIVE and BUS_INVALIDATE transactions onto the shared snooping bus on behalf of its own cache.
- Sequence: arbitrates for the bus, optionally writes back a dirty victim line, fetches the new line word by word through the read/write memory handshake, then commits data, tag and state into the cache arrays.
- Sits between the CPU-side cache controller, the bus arbiter, the memory/bus data path and the cache arrays.

Parameters:
- OFFSET_WIDTH, 4, word-offset bits; line = 2^OFFSET_WIDTH words.
- INDEX_WIDTH, 4, set-index bits.
- TAG_WIDTH, 8, tag bits; address width A = TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH.
- DATA_WIDTH, 16, word width.
- STATE_WIDTH, 2, coherence state width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_request  in  1  start transaction; sampled only in IDLE.
- cpu_command  in  2  commands-package encoding: NONE, BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE.
- cpu_address  in  A  target address; offset field ignored.
- victim_write_back  in  1  victim line dirty; write it back before fetch.
- victim_tag  in  TAG_WIDTH  tag of victim line.
- new_state  in  STATE_WIDTH  state to commit (from protocol block).
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- bus_request  out  1  arbiter request.
- bus_grant  in  1  arbiter grant.
- bus_command  out  2  command driven to snoopers.
- bus_command_valid  out  1  bus_command is valid.
- mem_address  out  A  memory word address.
- mem_read_enable / mem_write_enable  out  1 each  memory strobes.
- mem_data_out  out  DATA_WIDTH  write-back data.
- mem_data_in  in  DATA_WIDTH  fetched data.
- mem_function_complete  in  1  memory acknowledge.
- cache_index  out  INDEX_WIDTH  array index.
- cache_offset  out  OFFSET_WIDTH  array word offset.
- cache_data_in  in  DATA_WIDTH  array read data (combinational).
- cache_data_out  out  DATA_WIDTH  array write data.
- cache_write_data  out  1  word write strobe.
- cache_tag_out  out  TAG_WIDTH  tag to write.
- cache_write_tag  out  1  tag write strobe.
- cache_state_out  out  STATE_WIDTH  state to write.
- cache_write_state  out  1  state write strobe.

Behaviour:
- Reset:
  - FSM goes to IDLE; word counter = 0.
  - Every output = 0, including mid-transaction.
  - bus_request drops on the cycle after reset is sampled.
- States: IDLE, ARBITRATE, WRITE_BACK, FETCH, INVALIDATE, COMMIT.
- IDLE:
  - busy = 0.
  - cpu_request=1 with cpu_command≠NONE: latch address, command, victim_tag, victim_write_back and new_state; go to ARBITRATE.
  - cpu_request with NONE is ignored.
  - Requests in any state other than IDLE are ignored.
- ARBITRATE:
  - bus_request=1, held continuously until COMMIT completes.
  - On bus_grant=1: INVALIDATE if command is BUS_INVALIDATE; otherwise WRITE_BACK if victim_write_back; otherwise FETCH.
  - No bus_command_valid and no memory strobes before grant.
  - bus_grant is ignored after ARBITRATE (the arbiter holds grant while request is high).
- Memory handshake (four-phase), per word:
  - Hold the strobe until mem_function_complete=1.
  - Deassert the strobe the next cycle.
  - Do not reassert until mem_function_complete=0.
- WRITE_BACK:
  - cache_offset = counter; mem_address = {victim_tag, index, counter}; mem_data_out = cache_data_in; mem_write_enable=1.
  - On complete: counter++.
  - After the all-ones word, wrap counter to 0 and go to FETCH.
- FETCH:
  - bus_command = latched command; bus_command_valid=1 for the whole state.
  - mem_address = {tag, index, counter}; mem_read_enable=1.
  - On complete: cache_data_out = mem_data_in, cache_write_data=1 for one cycle at cache_offset=counter, then counter++.
  - Last word (counter all ones): wrap to 0 and go to COMMIT.
- INVALIDATE: bus_command=BUS_INVALIDATE, bus_command_valid=1 for exactly one cycle, then COMMIT. No memory access.
- COMMIT, one cycle:
  - cache_write_state=1 with cache_state_out = latched new_state.
  - cache_write_tag=1 with latched tag, except for invalidate.
  - done=1.
  - Next state IDLE; bus_request=0 from then on.
- cache_index = latched index throughout busy.
- Latency, zero-wait memory (complete one cycle after strobe), no write-back: grant → done = 3·2^OFFSET_WIDTH + 1 cycles.

Test Plan:
- Clean read, OFFSET_WIDTH=2, tag 8'hA5, index 4'h3, new_state 2'b01, immediate grant: mem_address words {A5,3,0..3}; 4 cache_write_data pulses with memory data; bus_command_valid only in FETCH; COMMIT writes tag A5 and state 01; done exactly once.
- Dirty victim (victim_tag 8'h5A, BUS_READ_EXCLUSIVE): 4 writes to {5A,3,0..3} carrying cache_data_in, then 4 reads from {A5,3,0..3}; bus_command = BUS_READ_EXCLUSIVE during the fetch.
- BUS_INVALIDATE: bus_command_valid high for 1 cycle; no mem strobes; cache_write_state=1; cache_write_tag=0; done the following cycle.
- Grant delayed 5 cycles: bus_request high throughout; zero bus/memory activity until grant.
- Reset asserted after 2 fetched words: all outputs 0 the next cycle; a fresh request then completes normally, starting at word 0.
- Memory completes 3 cycles after each strobe; cpu_request pulsed mid-fetch: strobe low for ≥1 cycle between words; the extra request is ignored; a single done.
